// File: rtl/if_pkg.sv
// Shared constants and the prefetch queue entry layout for the instruction-fetch stage.
package if_pkg;
  localparam int INSTR_BYTES = 4;
  localparam int ADDR_W_DEF = 32;
  localparam int INSTR_W_DEF = 32;
  localparam logic [ADDR_W_DEF-1:0] RESET_PC_DEF = '0;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0]  pc_plus4;
    logic [INSTR_W_DEF-1:0] instr;
  } if_entry_t;
endpackage

// File: rtl/if_instr_fifo.sv
// Synchronous FIFO holding prefetched {pc_plus4, instr} entries; flush beats push.
module if_instr_fifo #(
  parameter int W = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + (AW+1)'(1);
      if (pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst && !flush && push) mem[wptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rptr[AW-1:0]];
  assign count = wptr - rptr;
endmodule

// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage: sequential prefetch into a small queue ahead of IF/ID,
// with branch redirect that flushes the queue and drops the outstanding read.
module if_prefetch_stage
  import if_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               Branch_taken,
  input  logic [ADDR_W-1:0]  Branch_Address,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] Instruction,
  output logic [ADDR_W-1:0]  PC_IF_stage
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = ADDR_W + INSTR_W;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] inflight_pc;
  logic              inflight;
  logic              cancel;
  logic [CW-1:0]     count;
  logic [CW:0]       credit;
  logic              push;
  logic              pop;
  logic              flush;
  logic [EW-1:0]     head;
  logic [EW-1:0]     push_entry;
  logic [EW-1:0]     shown;
  logic [EW-1:0]     last_q;

  // Queued entries plus the outstanding read may never exceed the queue size,
  // so a response always has a free slot.
  assign credit   = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign imem_req = rst & ~Branch_taken & (credit < (CW+1)'(DEPTH));
  assign imem_addr = fetch_pc;

  // A redirect in the response cycle kills that response.
  assign cancel     = Branch_taken;
  assign push       = rst & inflight & ~cancel;
  assign flush      = ~rst | Branch_taken;
  assign pop        = instr_valid & ~freeze & ~Branch_taken;
  assign push_entry = {inflight_pc + ADDR_W'(INSTR_BYTES), imem_rdata};

  if_instr_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (push_entry),
    .dout  (head),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      inflight_pc <= '0;
      inflight    <= 1'b0;
      last_q      <= '0;
    end else begin
      if (instr_valid) last_q <= head;
      if (Branch_taken) begin
        fetch_pc <= {Branch_Address[ADDR_W-1:2], 2'b00};
        inflight <= 1'b0;
      end else begin
        inflight <= imem_req;
        if (imem_req) begin
          inflight_pc <= fetch_pc;
          fetch_pc    <= fetch_pc + ADDR_W'(INSTR_BYTES);
        end
      end
    end
  end

  // With an empty queue the outputs keep showing the last head entry.
  assign instr_valid = (count != '0);
  assign shown       = instr_valid ? head : last_q;
  assign Instruction = shown[INSTR_W-1:0];
  assign PC_IF_stage = shown[EW-1:INSTR_W];
endmodule
